// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch-path types and default widths.
// Provides the fetch FSM state enum and width defaults.
package cpu_pkg;

  localparam int unsigned AddrWidthDef = 16;
  localparam int unsigned DataWidthDef = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/pc_counter.sv
// pc_counter: program counter with load and increment.
// Ports: clock, reset_n, load/load_value, incr -> pc.
module pc_counter
  import cpu_pkg::*;
#(
  parameter int unsigned          AddrWidth   = AddrWidthDef,
  parameter logic [AddrWidth-1:0] ResetVector = '0
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic [AddrWidth-1:0] load_value,
  input  logic                 incr,
  output logic [AddrWidth-1:0] pc
);

  localparam logic [AddrWidth-1:0] One = AddrWidth'(1);

  // Increment wraps silently at all-ones.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc <= ResetVector;
    end else if (load) begin
      pc <= load_value;
    end else if (incr) begin
      pc <= pc + One;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetcher.
// Ports: memory req/ack, IR data/load, valid/ready, redirect.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned          AddrWidth   = AddrWidthDef,
  parameter int unsigned          DataWidth   = DataWidthDef,
  parameter logic [AddrWidth-1:0] ResetVector = '0
) (
  input  logic                 clock,
  input  logic                 reset_n,
  output logic                 mem_req,
  output logic [AddrWidth-1:0] mem_addr,
  input  logic                 mem_ack,
  input  logic [DataWidth-1:0] mem_rdata,
  output logic [DataWidth-1:0] ir_data,
  output logic                 ir_load,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  output logic [AddrWidth-1:0] instr_pc,
  input  logic                 redirect,
  input  logic [AddrWidth-1:0] redirect_pc
);

  fetch_state_e state;
  fetch_state_e state_d;

  logic                 squash;
  logic                 squash_d;
  logic [AddrWidth-1:0] pc;
  logic [AddrWidth-1:0] old_addr;

  logic pc_load;
  logic pc_incr;
  logic take;
  logic drop;
  logic keep_addr;

  pc_counter #(
    .AddrWidth  (AddrWidth),
    .ResetVector(ResetVector)
  ) u_pc (
    .clock     (clock),
    .reset_n   (reset_n),
    .load      (pc_load),
    .load_value(redirect_pc),
    .incr      (pc_incr),
    .pc        (pc)
  );

  // While squashing, pc already holds the redirect
  // target; the bus must keep the old request address.
  assign mem_req  = (state == FETCH);
  assign mem_addr = squash ? old_addr : pc;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      squash <= 1'b0;
    end else begin
      state  <= state_d;
      squash <= squash_d;
    end
  end

  always_comb begin
    state_d   = state;
    squash_d  = squash;
    pc_load   = 1'b0;
    pc_incr   = 1'b0;
    take      = 1'b0;
    drop      = 1'b0;
    keep_addr = 1'b0;
    unique case (state)
      IDLE: begin
        state_d = FETCH;
        pc_load = redirect;
      end
      FETCH: begin
        if (squash) begin
          pc_load = redirect;
          if (mem_ack) begin
            squash_d = 1'b0;
            state_d  = IDLE;
          end
        end else if (redirect) begin
          // Acked data is dropped; an unacked request
          // stays on the bus until its ack arrives.
          pc_load = 1'b1;
          if (!mem_ack) begin
            squash_d  = 1'b1;
            keep_addr = 1'b1;
          end
        end else if (mem_ack) begin
          take    = 1'b1;
          pc_incr = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_load = 1'b1;
          drop    = 1'b1;
          state_d = FETCH;
        end else if (instr_ready) begin
          drop    = 1'b1;
          state_d = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      old_addr <= ResetVector;
    end else if (keep_addr) begin
      old_addr <= pc;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ir_data     <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      ir_load     <= 1'b0;
    end else begin
      ir_load <= take;
      if (take) begin
        ir_data     <= mem_rdata;
        instr_pc    <= pc;
        instr_valid <= 1'b1;
      end else if (drop) begin
        instr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench with a behavioural model.
// Drives memory, decoder handshake and redirects.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] ir_data;
  logic        ir_load;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [15:0] instr_pc;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit chk_on = 1'b0;

  int          mem_wait = 0;
  int          wcnt = 0;
  logic        resp_ack = 1'b0;
  logic [15:0] resp_data = 16'h0;
  logic        inj_ack = 1'b0;
  logic [15:0] inj_data = 16'h0;

  assign mem_ack   = resp_ack | inj_ack;
  assign mem_rdata = inj_ack ? inj_data : resp_data;

  always #5 clock = ~clock;

  fetch_unit dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .ir_data    (ir_data),
    .ir_load    (ir_load),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr_pc   (instr_pc),
    .redirect   (redirect),
    .redirect_pc(redirect_pc)
  );

  task automatic check(input string nm,
                       input logic [15:0] act,
                       input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  // Memory: word at a is 0x1000+a, after mem_wait cycles.
  always @(posedge clock) begin
    #1;
    if (mem_req) begin
      if (wcnt >= mem_wait) begin
        resp_ack  = 1'b1;
        resp_data = 16'h1000 + mem_addr;
        wcnt      = 0;
      end else begin
        resp_ack = 1'b0;
        wcnt++;
      end
    end else begin
      resp_ack = 1'b0;
      wcnt     = 0;
    end
  end

  // Behavioural model in terms of requests and
  // held instructions rather than FSM states.
  logic [15:0] m_pc = 16'h0;
  logic [15:0] m_addr = 16'h0;
  logic [15:0] m_ir = 16'h0;
  logic [15:0] m_ipc = 16'h0;
  logic        m_gap = 1'b1;
  logic        m_busy = 1'b0;
  logic        m_stale = 1'b0;
  logic        m_have = 1'b0;
  logic        m_load = 1'b0;
  wire  [15:0] m_tgt = redirect ? redirect_pc : m_pc;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_pc    <= 16'h0;
      m_addr  <= 16'h0;
      m_ir    <= 16'h0;
      m_ipc   <= 16'h0;
      m_gap   <= 1'b1;
      m_busy  <= 1'b0;
      m_stale <= 1'b0;
      m_have  <= 1'b0;
      m_load  <= 1'b0;
    end else begin
      m_load <= 1'b0;
      if (m_gap) begin
        m_gap  <= 1'b0;
        m_busy <= 1'b1;
        m_pc   <= m_tgt;
        m_addr <= m_tgt;
      end else if (m_busy) begin
        if (m_stale) begin
          m_pc <= m_tgt;
          if (mem_ack) begin
            m_stale <= 1'b0;
            m_busy  <= 1'b0;
            m_gap   <= 1'b1;
          end
        end else if (redirect) begin
          m_pc <= redirect_pc;
          if (mem_ack) m_addr <= redirect_pc;
          else m_stale <= 1'b1;
        end else if (mem_ack) begin
          m_ir   <= mem_rdata;
          m_ipc  <= m_addr;
          m_pc   <= m_addr + 16'h1;
          m_have <= 1'b1;
          m_load <= 1'b1;
          m_busy <= 1'b0;
        end
      end else if (m_have) begin
        if (redirect || instr_ready) begin
          m_have <= 1'b0;
          m_busy <= 1'b1;
          m_pc   <= m_tgt;
          m_addr <= m_tgt;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (chk_on) begin
      check("mem_req", {15'h0, mem_req}, {15'h0, m_busy});
      if (m_busy) check("mem_addr", mem_addr, m_addr);
      check("instr_valid", {15'h0, instr_valid},
            {15'h0, m_have});
      check("ir_load", {15'h0, ir_load}, {15'h0, m_load});
      check("ir_data", ir_data, m_ir);
      check("instr_pc", instr_pc, m_ipc);
    end
  end

  typedef struct {
    logic [15:0] d;
    logic [15:0] a;
    int          c;
  } ld_t;
  ld_t lq[$];

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (ir_load) lq.push_back('{ir_data, instr_pc, cyc});
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic do_reset();
    @(posedge clock);
    #3;
    redirect    = 1'b0;
    instr_ready = 1'b0;
    inj_ack     = 1'b0;
    mem_wait    = 0;
    reset_n     = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    lq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset_n = 1'b0;
    #1 chk_on = 1'b1;

    // Reset values and first request timing.
    do_reset();
    check("rst_mem_req", {15'h0, mem_req}, 16'h0);
    check("rst_mem_addr", mem_addr, 16'h0);
    check("rst_valid", {15'h0, instr_valid}, 16'h0);
    check("rst_ir_load", {15'h0, ir_load}, 16'h0);
    check("rst_ir_data", ir_data, 16'h0);
    check("rst_instr_pc", instr_pc, 16'h0);
    instr_ready = 1'b1;
    tick();
    check("first_req", {15'h0, mem_req}, 16'h1);
    check("first_addr", mem_addr, 16'h0);
    repeat (6) tick();
    check("stream_loads", 16'(lq.size()), 16'd3);
    if (lq.size() >= 3) begin
      for (int i = 0; i < 3; i++) begin
        check("stream_data", lq[i].d, 16'h1000 + 16'(i));
        check("stream_pc", lq[i].a, 16'(i));
      end
      check("stream_gap1", 16'(lq[1].c - lq[0].c), 16'd2);
      check("stream_gap2", 16'(lq[2].c - lq[1].c), 16'd2);
    end

    // Decoder stalls for 5 cycles.
    do_reset();
    tick();
    tick();
    repeat (5) begin
      tick();
      check("stall_valid", {15'h0, instr_valid}, 16'h1);
      check("stall_data", ir_data, 16'h1000);
      check("stall_req", {15'h0, mem_req}, 16'h0);
    end
    instr_ready = 1'b1;
    tick();
    check("stall_next_addr", mem_addr, 16'h0001);

    // Redirect while the fetch waits on a slow ack.
    do_reset();
    instr_ready = 1'b1;
    mem_wait = 3;
    tick();
    redirect    = 1'b1;
    redirect_pc = 16'h0040;
    tick();
    redirect = 1'b0;
    repeat (2) begin
      check("sq_addr_held", mem_addr, 16'h0000);
      tick();
    end
    check("sq_addr_held", mem_addr, 16'h0000);
    tick();
    check("sq_idle_req", {15'h0, mem_req}, 16'h0);
    check("sq_no_load", {15'h0, ir_load}, 16'h0);
    tick();
    check("sq_new_addr", mem_addr, 16'h0040);
    repeat (5) tick();
    check("sq_loaded", {15'h0, lq.size() > 0}, 16'h1);
    if (lq.size() > 0) begin
      check("sq_pc", lq[0].a, 16'h0040);
      check("sq_data", lq[0].d, 16'h1040);
    end
    mem_wait = 0;

    // Redirect coincident with instr_ready in HOLD.
    do_reset();
    tick();
    tick();
    redirect    = 1'b1;
    redirect_pc = 16'h0200;
    instr_ready = 1'b1;
    tick();
    redirect = 1'b0;
    check("rr_valid", {15'h0, instr_valid}, 16'h0);
    check("rr_addr", mem_addr, 16'h0200);
    repeat (3) tick();
    check("rr_loaded", {15'h0, lq.size() > 1}, 16'h1);
    if (lq.size() > 1) begin
      check("rr_pc", lq[1].a, 16'h0200);
      check("rr_data", lq[1].d, 16'h1200);
    end

    // Wrap of the pc at all-ones.
    do_reset();
    redirect    = 1'b1;
    redirect_pc = 16'hFFFF;
    instr_ready = 1'b1;
    tick();
    redirect = 1'b0;
    check("wrap_addr", mem_addr, 16'hFFFF);
    tick();
    check("wrap_pc", instr_pc, 16'hFFFF);
    check("wrap_data", ir_data, 16'h0FFF);
    tick();
    check("wrap_next", mem_addr, 16'h0000);

    // Asynchronous reset mid-wait, then a late ack.
    do_reset();
    instr_ready = 1'b1;
    tick();
    mem_wait = 3;
    tick();
    tick();
    tick();
    check("ar_pre_addr", mem_addr, 16'h0001);
    #1 reset_n = 1'b0;
    #1;
    check("ar_req", {15'h0, mem_req}, 16'h0);
    check("ar_addr", mem_addr, 16'h0);
    check("ar_valid", {15'h0, instr_valid}, 16'h0);
    check("ar_load", {15'h0, ir_load}, 16'h0);
    check("ar_data", ir_data, 16'h0);
    check("ar_pc", instr_pc, 16'h0);
    tick();
    reset_n  = 1'b1;
    inj_ack  = 1'b1;
    inj_data = 16'hBEEF;
    tick();
    inj_ack = 1'b0;
    check("late_load", {15'h0, ir_load}, 16'h0);
    check("late_valid", {15'h0, instr_valid}, 16'h0);
    check("late_addr", mem_addr, 16'h0000);
    repeat (8) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter AddrWidth, default 16, meaning the program counter and memory address width.
REQ-002 The block SHALL have parameter DataWidth, default 16, meaning the instruction word width.
REQ-003 The block SHALL have parameter ResetVector, default 0, meaning the first fetch address after reset.
REQ-004 The block SHALL have port clock  in  1  meaning the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset_n  in  1  meaning the reset, which is asynchronous and active-low.
REQ-006 The block SHALL have port mem_req  out  1  meaning the instruction memory read request.
REQ-007 The block SHALL have port mem_addr  out  AddrWidth  meaning the read address, valid while mem_req=1.
REQ-008 The block SHALL have port mem_ack  in  1  meaning that mem_rdata is valid this cycle.
REQ-009 The block SHALL have port mem_rdata  in  DataWidth  meaning the fetched word.
REQ-010 The block SHALL have port ir_data  out  DataWidth  meaning the data input of the downstream instruction register.
REQ-011 The block SHALL have port ir_load  out  1  meaning the clock enable of the downstream instruction register.
REQ-012 The block SHALL have port instr_valid  out  1  meaning that ir_data holds an unconsumed instruction.
REQ-013 The block SHALL have port instr_ready  in  1  meaning that the decoder accepts the instruction this cycle.
REQ-014 The block SHALL have port instr_pc  out  AddrWidth  meaning the address of the instruction on ir_data.
REQ-015 The block SHALL have port redirect  in  1  meaning a branch/jump request.
REQ-016 The block SHALL have port redirect_pc  in  AddrWidth  meaning the branch target, sampled when redirect=1.

Function
REQ-017 The FSM SHALL have the states IDLE, FETCH and HOLD, plus an internal squash flag and an internal register pc.
REQ-018 In IDLE, mem_req SHALL be 0, and the FSM SHALL move unconditionally to FETCH on the next edge.
REQ-019 In FETCH, mem_req SHALL be 1 and mem_addr SHALL equal pc, with mem_addr held stable until mem_ack.
REQ-020 On FETCH with mem_ack=1 and squash=0, the block SHALL register ir_data<=mem_rdata, instr_pc<=pc, pc<=pc+1, pulse ir_load for exactly 1 cycle, set instr_valid<=1, and move to HOLD.
REQ-021 The pc increment SHALL be modulo 2^AddrWidth, so all-ones wraps to 0 with no flag.
REQ-022 In HOLD, mem_req SHALL be 0, and ir_data/instr_pc SHALL stay stable.
REQ-023 In HOLD with instr_ready=1, the block SHALL clear instr_valid and move to FETCH on the next edge, giving a minimum fetch-to-fetch period of 2 cycles with 0-wait memory.
REQ-024 Latency SHALL be as follows: the edge at which mem_ack is sampled asserts instr_valid, with no extra registration stage.
REQ-025 A redirect in IDLE or HOLD SHALL set pc<=redirect_pc and instr_valid<=0 and move to FETCH, with any held instruction discarded.
REQ-026 A redirect coincident with instr_ready in HOLD SHALL make redirect win, with the instruction counted as discarded.
REQ-027 A redirect in FETCH with mem_ack=0 SHALL set pc<=redirect_pc and squash<=1, keep mem_addr at the old address until ack, discard the acked data (no ir_load), then clear squash and issue a new FETCH at the new pc after 1 cycle in IDLE.
REQ-028 A redirect in FETCH with mem_ack=1 SHALL discard the data (no ir_load, instr_valid stays 0), set pc<=redirect_pc, and move to FETCH next cycle.
REQ-029 A repeated redirect while squash=1 SHALL update pc only, with the last target winning.
REQ-030 mem_ack outside FETCH SHALL be ignored.
REQ-031 ir_load SHALL never be asserted in a cycle in which instr_valid is being cleared by redirect.

Reset
REQ-032 On reset_n=0, the block SHALL immediately (asynchronously) force state=IDLE, pc=ResetVector, squash=0, mem_req=0, ir_load=0, instr_valid=0, ir_data=0, instr_pc=0, and mem_addr=ResetVector.
REQ-033 Reset mid-fetch SHALL abandon the request, and a late mem_ack after reset release while not in FETCH SHALL be ignored.
REQ-034 The first mem_req SHALL rise 1 cycle after the first clock edge with reset_n=1.

Structure
REQ-035 The FSM state enum (IDLE/FETCH/HOLD) and the default width constants SHALL reside in shared package cpu_pkg.
REQ-036 The block SHALL use one sub-module, pc_counter, which provides load/increment of the AddrWidth-bit pc with asynchronous active-low reset to ResetVector.
REQ-037 All outputs SHALL be registered except mem_req and mem_addr, which are decoded from registered state/pc.

Verification
REQ-038 Bench scenario: reset release, 0-wait memory returning 0x1000+addr, instr_ready=1 -> ir_data 0x1000,0x1001,0x1002 at addresses 0,1,2, with one ir_load pulse each 2 cycles.
REQ-039 Bench scenario: instr_ready held 0 for 5 cycles after the first fetch -> instr_valid stays 1, ir_data stays 0x1000, mem_req stays 0, and pc stays 1.
REQ-040 Bench scenario: redirect to 0x0040 while FETCH is waiting (ack delayed 3 cycles) -> stale word discarded with no ir_load, next mem_addr=0x0040, and instr_pc=0x0040.
REQ-041 Bench scenario: redirect to 0x0200 coincident with instr_ready in HOLD -> instr_valid drops, and the next valid instruction has instr_pc=0x0200.
REQ-042 Bench scenario: pc=0xFFFF fetched -> next mem_addr=0x0000.
REQ-043 Bench scenario: reset_n pulsed low mid-WAIT -> outputs reach their reset values without a clock edge, and the late ack produces no ir_load.
